adder: RTL and testbench

- Parameterised n-bit binary adder computing x + y + cin, with sum and carry-out registered on the clock.
- Arithmetic core of the CPU datapath (ALU add path, PC increment); also supplies the signed-overflow flag for the V condition bit.
- Ripple-carry structure built from a full-adder cell, followed by one output register stage.

---
 rtl/adder_pkg.sv | 6 +
 rtl/adder_full_adder.sv | 16 +
 rtl/adder.sv | 60 ++++++
 tb/tb_adder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package adder_pkg;

  localparam int n_default = 8;

endpackage

// File: rtl/adder_full_adder.sv
// Single-bit full adder cell. The ripple chain in adder is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder.sv
// n-bit ripple-carry adder with registered sum, carry-out and signed overflow.
// One-cycle latency. The outputs come straight from flops, so they are glitch-free.
module adder
  import adder_pkg::*;
#(
  parameter int n = n_default
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         cin,
  output logic [n-1:0] z,
  output logic         cout,
  output logic         ovf
);

  logic [n:0]   c;
  logic [n-1:0] z_next;
  logic         cout_next;
  logic         ovf_next;
  logic [n-1:0] z_reg;
  logic         cout_reg;
  logic         ovf_reg;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < n; gi++) begin : g_fa
      full_adder u_fa (
        .a  (x[gi]),
        .b  (y[gi]),
        .ci (c[gi]),
        .s  (z_next[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  // The carry into and out of the sign bit differ exactly when the signed result overflows.
  assign cout_next = c[n];
  assign ovf_next  = c[n] ^ c[n-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_reg    <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      z_reg    <= z_next;
      cout_reg <= cout_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign z    = z_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_adder.sv
// Directed and random stimulus for adder at n=8 and n=16.
// Expected results are queued as each operand set is driven, then popped after the next edge.
module tb_adder;

  typedef struct {
    logic [15:0] z;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  x8, y8, z8;
  logic        cin8, cout8, ovf8;
  logic [15:0] x16, y16, z16;
  logic        cin16, cout16, ovf16;

  int checks   = 0;
  int failures = 0;

  exp_t q8[$];
  exp_t q16[$];

  adder #(.n(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .x    (x8),
    .y    (y8),
    .cin  (cin8),
    .z    (z8),
    .cout (cout8),
    .ovf  (ovf8)
  );

  adder #(.n(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .x    (x16),
    .y    (y16),
    .cin  (cin16),
    .z    (z16),
    .cout (cout16),
    .ovf  (ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      $error("%s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    exp_t e;
    logic [8:0] sum;
    sum    = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    e.z    = {8'd0, sum[7:0]};
    e.cout = sum[8];
    e.ovf  = (a[7] == b[7]) && (sum[7] != a[7]);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t e;
    logic [16:0] sum;
    sum    = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.z    = sum[15:0];
    e.cout = sum[16];
    e.ovf  = (a[15] == b[15]) && (sum[15] != a[15]);
    return e;
  endfunction

  task automatic pop8(input string tag);
    exp_t e;
    if (q8.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = q8.pop_front();
      chk({tag, "_z"}, {56'd0, z8}, {48'd0, e.z});
      chk({tag, "_cout"}, {63'd0, cout8}, {63'd0, e.cout});
      chk({tag, "_ovf"}, {63'd0, ovf8}, {63'd0, e.ovf});
      $display("txn %s n=8 z=%0d cout=%0d ovf=%0d", tag, z8, cout8, ovf8);
    end
  endtask

  task automatic pop16(input string tag);
    exp_t e;
    if (q16.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = q16.pop_front();
      chk({tag, "_z"}, {48'd0, z16}, {48'd0, e.z});
      chk({tag, "_cout"}, {63'd0, cout16}, {63'd0, e.cout});
      chk({tag, "_ovf"}, {63'd0, ovf16}, {63'd0, e.ovf});
      $display("txn %s n=16 z=%0d cout=%0d ovf=%0d", tag, z16, cout16, ovf16);
    end
  endtask

  // Drive one 8-bit operand set, wait exactly one edge, then compare.
  task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci);
    x8 = a; y8 = b; cin8 = ci;
    q8.push_back(model8(a, b, ci));
    @(posedge clk); #1;
    pop8(tag);
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_z"}, {56'd0, z8}, 64'd0);
    chk({tag, "_cout"}, {63'd0, cout8}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, ovf8}, 64'd0);
    $display("txn %s n=8 z=%0d cout=%0d ovf=%0d", tag, z8, cout8, ovf8);
  endtask

  initial begin
    rst = 1'b1;
    x8 = '0; y8 = '0; cin8 = 1'b0;
    x16 = '0; y16 = '0; cin16 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_zero8("reset_hold");
    end
    rst = 1'b0;

    step8("zero_after_reset", 8'd0, 8'd0, 1'b0);
    step8("mixed_sign", 8'd200, 8'd100, 1'b1);
    step8("wrap_255", 8'd255, 8'd0, 1'b1);
    step8("pos_ovf", 8'd127, 8'd1, 1'b0);

    // Back-to-back operands, with no idle cycle between them.
    step8("b2b_0", 8'd10, 8'd20, 1'b0);
    step8("b2b_1", 8'd128, 8'd128, 1'b0);
    step8("b2b_2", 8'd5, 8'd250, 1'b1);

    // An asynchronous reset between edges must clear the outputs without a clock edge.
    step8("pre_async", 8'd100, 8'd50, 1'b0);
    #2 rst = 1'b1;
    #1 chk_zero8("async_rst_mid");
    @(posedge clk); #1;
    chk_zero8("async_rst_edge");
    rst = 1'b0;
    step8("post_async", 8'd100, 8'd50, 1'b0);

    for (int i = 0; i < 24; i++) begin
      x8  = 8'($urandom_range(0, 255));
      y8  = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      x16 = 16'($urandom_range(0, 65535));
      y16 = 16'($urandom_range(0, 65535));
      cin16 = 1'($urandom_range(0, 1));
      q8.push_back(model8(x8, y8, cin8));
      q16.push_back(model16(x16, y16, cin16));
      @(posedge clk); #1;
      pop8("rand8");
      pop16("rand16");
    end

    chk("queue8_drained", 64'(q8.size()), 64'd0);
    chk("queue16_drained", 64'(q16.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
